mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Merges the pipelined core's instruction-fetch port and memory-stage data port onto one shared,
//  variable-latency memory with a req/ack handshake. Next-generation memory interface: parametrised
//  width, byte-lane stores/loads, bus timeout, and a stall output that freezes the pipeline while
//  either port waits. Sits between processor and the unified memory model.
// PARAMETERS
//  DATA_WIDTH     32  data bus width; multiple of 8, >=16
//  ADDR_WIDTH     32  byte address width
//  TIMEOUT        16  cycles in an access state without mem_ack before abort; 0 disables timeout
//  SIGN_EXT_BYTE  1   1: byte loads sign-extended; 0: zero-extended
// PORTS
//  clk               in   1            rising-edge clock
//  reset             in   1            synchronous, active-high
//  fetch_req         in   1            level: core wants instruction at pc_fetch
//  pc_fetch          in   ADDR_WIDTH   instruction byte address
//  fetch_done        out  1            1-cycle pulse: instr_fetch valid
//  instr_fetch       out  DATA_WIDTH   fetched instruction (held until next fetch_done)
//  data_req          in   1            level: memory-stage load/store pending
//  mem_write_memory  in   1            1 store, 0 load
//  write_or_byte     in   1            1 byte access, 0 full word
//  alu_out_memory    in   ADDR_WIDTH   data byte address
//  write_data_memory in   DATA_WIDTH   store data (byte stores use bits [7:0])
//  data_done         out  1            1-cycle pulse: load data valid / store retired
//  read_data_memory  out  DATA_WIDTH   load result (held until next data_done)
//  stall             out  1            (fetch_req & ~fetch_done) | (data_req & ~data_done)
//  bus_error         out  1            sticky: an access timed out; cleared only by reset
//  mem_req           out  1            memory request, registered
//  mem_we            out  1            memory write enable
//  mem_addr          out  ADDR_WIDTH   word-aligned address (low log2(DATA_WIDTH/8) bits = 0)
//  mem_be            out  DATA_WIDTH/8 byte enables
//  mem_wdata         out  DATA_WIDTH   write data
//  mem_ack           in   1            memory completes current access (1-cycle)
//  mem_rdata         in   DATA_WIDTH   read data, valid when mem_ack=1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (instr_fetch, read_data_memory, bus_error, mem_* included).
//  FSM states: IDLE, D_ACC, I_ACC, D_RESP, I_RESP.
//   IDLE : data_req -> D_ACC; else fetch_req -> I_ACC; else stay. Data wins (older instruction).
//   D_ACC/I_ACC: mem_req=1; mem_we/addr/be/wdata registered on entry, stable until exit.
//     mem_ack sampled high -> capture mem_rdata, go to matching *_RESP.
//     wait counter reaches TIMEOUT (TIMEOUT>0) w/o ack -> set bus_error, result=0, go *_RESP.
//   D_RESP/I_RESP: one cycle, done pulse asserted, mem_req=0, -> IDLE. Requests are never
//     re-evaluated in RESP, so a still-high req in the done cycle is not re-issued.
//  Minimum latency: req seen in IDLE at cycle 0, mem_req cycle 1, ack cycle 1, done cycle 2.
//  Fetch: mem_we=0, mem_be all ones; instr_fetch <= mem_rdata.
//  Word data: mem_be all ones; load returns mem_rdata unmodified; low address bits ignored.
//  Byte data (lane k = alu_out_memory low bits): mem_be one-hot at k; mem_wdata = byte replicated
//   into every lane; load returns lane k, extended per SIGN_EXT_BYTE.
//  mem_ack outside D_ACC/I_ACC ignored. Wait counter clears on every access entry.
//  Request dropped mid-access: access completes anyway; done still pulses once.
//  Reset mid-access: mem_req drops next edge, no done pulse, FSM to IDLE.
//  bus_error never blocks further accesses.
// TESTING
//  fetch_req=1, pc_fetch=0x40, ack 1 cycle after mem_req, rdata=0x2008_0005 -> mem_addr=0x40, be=4'hF, fetch_done 1 pulse, instr_fetch=0x2008_0005.
//  data_req & fetch_req same cycle -> data served first, then fetch; exactly one done each, stall high until fetch_done.
//  byte store addr=0x103, wdata=0xAB -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1.
//  byte load addr=0x101, rdata=0x0000_8000, SIGN_EXT_BYTE=1 -> read_data_memory=0xFFFF_FF80.
//  TIMEOUT=4, never ack -> mem_req drops after 4 wait cycles, data_done pulses, result 0, bus_error stays 1.
//  reset asserted during D_ACC -> next cycle mem_req=0, no data_done, all outputs 0, bus_error=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared memory bus between the fetch/data arbiter (master) and the unified memory (slave).
// Single-beat req/ack handshake; mem_rdata is valid only while mem_ack is high.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch and data ports onto one variable-latency memory.
// Data beats fetch in IDLE; each access gets a wait counter so a missing ack aborts with bus_error.
module mem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int TIMEOUT       = 16,
    parameter bit SIGN_EXT_BYTE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] pc_fetch,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] instr_fetch,
    input  logic                  data_req,
    input  logic                  mem_write_memory,
    input  logic                  write_or_byte,
    input  logic [ADDR_WIDTH-1:0] alu_out_memory,
    input  logic [DATA_WIDTH-1:0] write_data_memory,
    output logic                  data_done,
    output logic [DATA_WIDTH-1:0] read_data_memory,
    output logic                  stall,
    output logic                  bus_error,
    mem_port_arbiter_if.master    mem
);
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int LANE_BITS = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LANE_BITS) - 1);

    typedef enum logic [2:0] {IDLE, D_ACC, I_ACC, D_RESP, I_RESP} state_t;

    state_t               state;
    logic [CW-1:0]        wait_cnt;
    logic                 acc_byte;
    logic                 acc_load;
    logic [LANE_BITS-1:0] acc_lane;
    logic                 timed_out;
    logic [7:0]           lane_byte;
    logic [DATA_WIDTH-1:0] load_val;

    assign stall     = (fetch_req & ~fetch_done) | (data_req & ~data_done);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
    assign lane_byte = mem.mem_rdata[{acc_lane, 3'b000} +: 8];

    always_comb begin
        load_val = mem.mem_rdata;
        if (acc_byte)
            load_val = SIGN_EXT_BYTE ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte}
                                     : {{(DATA_WIDTH-8){1'b0}}, lane_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            acc_byte         <= 1'b0;
            acc_load         <= 1'b0;
            acc_lane         <= '0;
            fetch_done       <= 1'b0;
            data_done        <= 1'b0;
            instr_fetch      <= '0;
            read_data_memory <= '0;
            bus_error        <= 1'b0;
            mem.mem_req      <= 1'b0;
            mem.mem_we       <= 1'b0;
            mem.mem_addr     <= '0;
            mem.mem_be       <= '0;
            mem.mem_wdata    <= '0;
        end else begin
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (data_req) begin
                        state         <= D_ACC;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= mem_write_memory;
                        mem.mem_addr  <= alu_out_memory & ADDR_MASK;
                        mem.mem_be    <= write_or_byte ? BE_W'(1) << alu_out_memory[LANE_BITS-1:0]
                                                       : {BE_W{1'b1}};
                        mem.mem_wdata <= write_or_byte ? {BE_W{write_data_memory[7:0]}}
                                                       : write_data_memory;
                        acc_byte      <= write_or_byte;
                        acc_load      <= ~mem_write_memory;
                        acc_lane      <= alu_out_memory[LANE_BITS-1:0];
                    end else if (fetch_req) begin
                        state         <= I_ACC;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= pc_fetch & ADDR_MASK;
                        mem.mem_be    <= {BE_W{1'b1}};
                        mem.mem_wdata <= '0;
                    end
                end
                D_ACC, I_ACC: begin
                    // An abort completes like an ack but returns zero and latches the error.
                    if (mem.mem_ack || timed_out) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_ack)
                            bus_error <= 1'b1;
                        if (state == I_ACC) begin
                            instr_fetch <= mem.mem_ack ? mem.mem_rdata : '0;
                            fetch_done  <= 1'b1;
                            state       <= I_RESP;
                        end else begin
                            if (!mem.mem_ack)
                                read_data_memory <= '0;
                            else if (acc_load)
                                read_data_memory <= load_val;
                            data_done <= 1'b1;
                            state     <= D_RESP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected bus beats and done results are queued at stimulus time and
// compared when the arbiter issues a request or pulses a done.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, data_req, mem_write_memory, write_or_byte;
    logic [31:0] pc_fetch, alu_out_memory, write_data_memory;
    logic        fetch_done, data_done, stall, bus_error;
    logic [31:0] instr_fetch, read_data_memory;

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO), .SIGN_EXT_BYTE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .pc_fetch(pc_fetch), .fetch_done(fetch_done), .instr_fetch(instr_fetch),
        .data_req(data_req), .mem_write_memory(mem_write_memory), .write_or_byte(write_or_byte),
        .alu_out_memory(alu_out_memory), .write_data_memory(write_data_memory),
        .data_done(data_done), .read_data_memory(read_data_memory),
        .stall(stall), .bus_error(bus_error), .mem(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [7:0]  len;
    } bus_t;

    typedef struct packed {
        logic        is_data;
        logic        chk_val;
        logic [31:0] val;
    } done_t;

    bus_t  exp_bus[$];
    done_t exp_done[$];
    int    n_pass = 0, n_chk = 0;
    int    ack_delay = 0;
    bit    never_ack = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h40)  return 32'h2008_0005;
        if (a == 32'h100) return 32'h0000_8000;
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] lane, input bit bt);
        logic [7:0] b;
        b = 8'(w >> (32'(lane) * 8));
        return bt ? {{24{b[7]}}, b} : w;
    endfunction

    // memory model: acks ack_delay cycles after the request becomes visible
    initial begin
        int wait_n;
        wait_n = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !never_ack) begin
                if (wait_n >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rdata_for(bus.mem_addr);
                    wait_n = 0;
                end else wait_n++;
            end else wait_n = 0;
        end
    end

    // monitor: pops expectations on request rise and on done pulses
    initial begin
        bit   prev_req;
        int   req_len;
        bus_t cur;
        done_t d;
        prev_req = 0; req_len = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                req_len = 0;
                if (exp_bus.size() == 0) chk("spurious_req", 32'd1, 32'd0);
                else begin
                    cur = exp_bus.pop_front();
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
                    chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end
            if (bus.mem_req) req_len++;
            if (!bus.mem_req && prev_req && cur.len != 0) chk("req_len", 32'(req_len), 32'(cur.len));
            prev_req = bus.mem_req;
            if (fetch_done || data_done) begin
                if (exp_done.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    d = exp_done.pop_front();
                    chk("done_kind", 32'(data_done), 32'(d.is_data));
                    if (d.chk_val) chk(d.is_data ? "read_data" : "instr_fetch",
                                       d.is_data ? read_data_memory : instr_fetch, d.val);
                end
            end
        end
    end

    task automatic run(input bit df, input logic [31:0] pc, input bit dd, input bit we,
                       input bit bt, input logic [31:0] a, input logic [31:0] wd, input bit tmo);
        logic [31:0] wa;
        logic [7:0]  len;
        @(negedge clk);
        len = tmo ? 8'(TO) : 8'(ack_delay + 1);
        if (dd) begin
            wa = a & ~32'h3;
            exp_bus.push_back('{wa, bt ? 4'b0001 << a[1:0] : 4'hF, we, bt ? {4{wd[7:0]}} : wd, len});
            exp_done.push_back('{1'b1, !we, tmo ? 32'h0 : exp_load(rdata_for(wa), a[1:0], bt)});
        end
        if (df) begin
            wa = pc & ~32'h3;
            exp_bus.push_back('{wa, 4'hF, 1'b0, 32'h0, len});
            exp_done.push_back('{1'b0, 1'b1, tmo ? 32'h0 : rdata_for(wa)});
        end
        fetch_req = df; pc_fetch = pc;
        data_req = dd; mem_write_memory = we; write_or_byte = bt;
        alu_out_memory = a; write_data_memory = wd;
        for (int c = 0; c < 60 && (fetch_req || data_req); c++) begin
            @(negedge clk);
            chk("stall", 32'(stall), 32'((fetch_req && !fetch_done) || (data_req && !data_done)));
            if (fetch_done) fetch_req = 1'b0;
            if (data_done) data_req = 1'b0;
        end
        if (fetch_req || data_req) begin
            chk("done_timeout", 32'd1, 32'd0);
            fetch_req = 1'b0; data_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_bus.size() + exp_done.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 0; data_req = 0; mem_write_memory = 0; write_or_byte = 0;
        pc_fetch = 0; alu_out_memory = 0; write_data_memory = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_outs", {instr_fetch | read_data_memory | bus.mem_addr | bus.mem_wdata},  32'd0);
        chk("rst_flags", 32'({fetch_done, data_done, bus_error, bus.mem_we, bus.mem_be}), 32'd0);
        reset = 1'b0;

        ack_delay = 0;
        run(1, 32'h40, 0, 0, 0, 0, 0, 0);                    // fetch 0x40
        run(1, 32'h80, 1, 0, 0, 32'h100, 0, 0);              // data then fetch
        run(0, 0, 1, 1, 1, 32'h103, 32'h0000_00AB, 0);       // byte store lane 3
        run(0, 0, 1, 0, 1, 32'h101, 0, 0);                   // byte load, sign-extended
        ack_delay = 2;
        run(0, 0, 1, 0, 0, 32'h106, 0, 0);                   // word load, low bits ignored
        run(0, 0, 1, 1, 0, 32'h208, 32'hDEAD_BEEF, 0);       // word store
        for (int l = 0; l < 4; l++) run(0, 0, 1, 0, 1, 32'h3C0 + 32'(l), 0, 0);
        for (int i = 0; i < 8; i++) begin
            ack_delay = int'($urandom_range(0, 2));
            run($urandom_range(0, 1) == 1, $urandom_range(0, 32'hFFF), 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 32'hFFF), $urandom, 0);
        end

        never_ack = 1;
        run(0, 0, 1, 0, 0, 32'h200, 0, 1);                   // timeout abort
        chk("bus_error_set", 32'(bus_error), 32'd1);
        never_ack = 0; ack_delay = 1;
        run(1, 32'h44, 0, 0, 0, 0, 0, 0);
        chk("bus_error_sticky", 32'(bus_error), 32'd1);

        // reset during D_ACC
        never_ack = 1;
        @(negedge clk);
        exp_bus.push_back('{32'h300, 4'hF, 1'b0, 32'h0, 8'd0});
        data_req = 1; mem_write_memory = 0; write_or_byte = 0; alu_out_memory = 32'h300;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1; data_req = 0;
        @(negedge clk);
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_done", 32'(data_done), 32'd0);
        chk("midrst_err", 32'(bus_error), 32'd0);
        chk("midrst_data", read_data_memory | instr_fetch, 32'd0);
        reset = 1'b0; never_ack = 0; ack_delay = 0;
        run(0, 0, 1, 0, 1, 32'h102, 0, 0);                   // recovers after reset
        chk("sb_final", 32'(exp_bus.size() + exp_done.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
